profile_ci: RTL and testbench



---
 rtl/profile_pkg.sv | 11 +
 rtl/profile_ci_if.sv | 12 +
 rtl/profile_ci_counter.sv | 14 +
 rtl/profile_ci.sv | 57 +++++
 tb/tb_profile_ci.sv | 118 +++++++++++
 5 files changed

// File: rtl/profile_pkg.sv
// profile_pkg: counter indices, control-word field offsets and FSM states for profile_ci
package profile_pkg;
  localparam int CNT_CYCLES = 0;
  localparam int CNT_STALL = 1;
  localparam int CNT_IDLE = 2;
  localparam int CNT_BUSY = 3;
  localparam int EN_LSB = 0;
  localparam int DIS_LSB = 4;
  localparam int CLR_LSB = 8;
  typedef enum logic {IDLE, RESPOND} state_t;
endpackage

// File: rtl/profile_ci_if.sv
// profile_ci_if: CPU custom-instruction request/response port
interface profile_ci_if;
  logic ciStart;
  logic ciCke;
  logic [7:0] ciN;
  logic [31:0] ciValueA;
  logic [31:0] ciValueB;
  logic ciDone;
  logic [31:0] ciResult;
  modport master (output ciStart, ciCke, ciN, ciValueA, ciValueB, input ciDone, ciResult);
  modport slave (input ciStart, ciCke, ciN, ciValueA, ciValueB, output ciDone, ciResult);
endinterface

// File: rtl/profile_ci_counter.sv
// profile_ci_counter: up/down counter with sync reset and enable
module profile_ci_counter #(
  parameter int WIDTH = 32
) (
  input logic clk,
  input logic rst,
  input logic en,
  input logic up,
  output logic [WIDTH-1:0] value
);
  always_ff @(posedge clk)
    if (rst) value <= '0;
    else if (en) value <= up ? value + 1'b1 : value - 1'b1;
endmodule

// File: rtl/profile_ci.sv
// profile_ci: custom-instruction front end for four profiling counters (PROFILE_SATURATE_EN: counters stick at all-ones)
module profile_ci
  import profile_pkg::*;
#(
  parameter logic [7:0] CUSTOM_ID = 8'd12,
  parameter int WIDTH = 32
) (
  input logic clock,
  input logic reset,
  input logic stall,
  input logic busIdle,
  profile_ci_if.slave ci
);
  state_t state, state_nxt;
  logic accept;
  logic [3:0] en_reg, clr, inc, cnt_en;
  logic [WIDTH-1:0] cnt [4];
  logic [31:0] res_q;
  logic unused_bits;
  assign unused_bits = ^{ci.ciValueA[31:2], ci.ciValueB[31:12]};
  always_comb begin
    accept = ci.ciStart & ci.ciCke & (ci.ciN == CUSTOM_ID) & (state == IDLE);
    state_nxt = accept ? RESPOND : IDLE;
    clr = accept ? ci.ciValueB[CLR_LSB +: 4] : 4'b0;
    inc[CNT_CYCLES] = en_reg[CNT_CYCLES];
    inc[CNT_STALL] = en_reg[CNT_STALL] & stall;
    inc[CNT_IDLE] = en_reg[CNT_IDLE] & busIdle;
    inc[CNT_BUSY] = en_reg[CNT_BUSY] & ~stall & ~busIdle;
  end
  always_ff @(posedge clock)
    if (reset) begin
      state <= IDLE;
      en_reg <= '0;
      res_q <= '0;
    end else begin
      state <= state_nxt;
      res_q <= accept ? 32'(cnt[ci.ciValueA[1:0]]) : '0;
      if (accept) en_reg <= (en_reg | ci.ciValueB[EN_LSB +: 4]) & ~ci.ciValueB[DIS_LSB +: 4];
    end
  // reset gates the outputs so a response cut short by reset never shows a done pulse
  assign ci.ciDone = (state == RESPOND) & ~reset;
  assign ci.ciResult = reset ? '0 : res_q;
  for (genvar i = 0; i < 4; i++) begin : g_cnt
`ifdef PROFILE_SATURATE_EN
    assign cnt_en[i] = inc[i] & (cnt[i] != '1);
`else
    assign cnt_en[i] = inc[i];
`endif
    profile_ci_counter #(.WIDTH(WIDTH)) u_cnt (
      .clk(clock),
      .rst(reset | clr[i]),
      .en(cnt_en[i]),
      .up(1'b1),
      .value(cnt[i])
    );
  end
endmodule

// File: tb/tb_profile_ci.sv
// tb_profile_ci: directed checks of profile_ci handshake, enables, clears, reset abort and 4-bit overflow
module tb_profile_ci;
  logic clock = 1'b0;
  logic reset, stall, busIdle;
  int n_assert = 0;
  int n_fail = 0;
  logic d;
  logic [31:0] r;
  profile_ci_if ci ();
  profile_ci_if ci4 ();
  always #5 clock = ~clock;
  profile_ci u_dut (.clock(clock), .reset(reset), .stall(stall), .busIdle(busIdle), .ci(ci));
  profile_ci #(.WIDTH(4)) u_dut4 (.clock(clock), .reset(reset), .stall(stall), .busIdle(busIdle), .ci(ci4));
  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic drive(input bit w, input logic s, input logic [7:0] id, input logic cke, input logic [31:0] a, input logic [31:0] b);
    if (w) begin
      ci4.ciStart = s; ci4.ciN = id; ci4.ciCke = cke; ci4.ciValueA = a; ci4.ciValueB = b;
    end else begin
      ci.ciStart = s; ci.ciN = id; ci.ciCke = cke; ci.ciValueA = a; ci.ciValueB = b;
    end
  endtask
  task automatic req(input bit w, input logic [7:0] id, input logic cke, input logic [31:0] a, input logic [31:0] b,
                     output logic od, output logic [31:0] orr);
    drive(w, 1'b1, id, cke, a, b);
    tick(1);
    od = w ? ci4.ciDone : ci.ciDone;
    orr = w ? ci4.ciResult : ci.ciResult;
    drive(w, 1'b0, 8'd0, 1'b0, 32'd0, 32'd0);
    tick(1);
  endtask
  initial begin
    reset = 1'b1; stall = 1'b0; busIdle = 1'b0;
    drive(0, 1'b0, 8'd0, 1'b0, 32'd0, 32'd0);
    drive(1, 1'b0, 8'd0, 1'b0, 32'd0, 32'd0);
    tick(2);
    check("reset_done", {31'd0, ci.ciDone}, 32'd0);
    check("reset_result", ci.ciResult, 32'd0);
    reset = 1'b0;
    #1;
    check("idle_done", {31'd0, ci.ciDone}, 32'd0);
    req(0, 8'd12, 1'b1, 32'd0, 32'h00F, d, r);
    check("en_all_done", {31'd0, d}, 32'd1);
    check("en_all_result", r, 32'd0);
    tick(10);
    req(0, 8'd12, 1'b1, 32'd0, 32'h000, d, r);
    check("c0_11_done", {31'd0, d}, 32'd1);
    check("c0_11_result", r, 32'd11);
    check("after_resp_done", {31'd0, ci.ciDone}, 32'd0);
    check("after_resp_result", ci.ciResult, 32'd0);
    req(0, 8'd12, 1'b1, 32'd0, 32'h3D2, d, r);
    check("c1_only_capture", r, 32'd13);
    stall = 1'b1;
    tick(5);
    stall = 1'b0;
    tick(3);
    req(0, 8'd12, 1'b1, 32'd1, 32'h000, d, r);
    check("c1_stall5", r, 32'd5);
    req(0, 8'd12, 1'b1, 32'd0, 32'h000, d, r);
    check("c0_off", r, 32'd0);
    req(0, 8'd12, 1'b1, 32'd0, 32'h001, d, r);
    check("c0_enable", r, 32'd0);
    tick(20);
    req(0, 8'd12, 1'b1, 32'd0, 32'h100, d, r);
    check("pre_clear", r, 32'd21);
    req(0, 8'd12, 1'b1, 32'd0, 32'h000, d, r);
    check("post_clear", r, 32'd1);
    req(0, 8'd13, 1'b1, 32'd0, 32'h0F0, d, r);
    check("bad_id_done", {31'd0, d}, 32'd0);
    check("bad_id_result", r, 32'd0);
    req(0, 8'd12, 1'b0, 32'd0, 32'h0F0, d, r);
    check("cke0_done", {31'd0, d}, 32'd0);
    check("cke0_result", r, 32'd0);
    req(0, 8'd12, 1'b1, 32'd0, 32'h000, d, r);
    check("en_unchanged", r, 32'd7);
    req(0, 8'd12, 1'b1, 32'd0, 32'h111, d, r);
    check("en_dis_capture", r, 32'd9);
    tick(3);
    req(0, 8'd12, 1'b1, 32'd0, 32'h000, d, r);
    check("disable_wins", r, 32'd0);
    drive(0, 1'b1, 8'd12, 1'b1, 32'd0, 32'h001);
    tick(1);
    reset = 1'b1;
    drive(0, 1'b0, 8'd0, 1'b0, 32'd0, 32'd0);
    #1;
    check("rst_resp_done", {31'd0, ci.ciDone}, 32'd0);
    check("rst_resp_result", ci.ciResult, 32'd0);
    tick(1);
    reset = 1'b0;
    #1;
    check("rst_next_done", {31'd0, ci.ciDone}, 32'd0);
    req(0, 8'd12, 1'b1, 32'd0, 32'h001, d, r);
    check("rst_cleared", r, 32'd0);
    req(0, 8'd12, 1'b1, 32'd0, 32'h000, d, r);
    check("rst_c0_off", r, 32'd1);
    req(1, 8'd12, 1'b1, 32'd0, 32'h001, d, r);
    check("w4_done", {31'd0, d}, 32'd1);
    check("w4_enable", r, 32'd0);
    tick(19);
    req(1, 8'd12, 1'b1, 32'd0, 32'h000, d, r);
`ifdef PROFILE_SATURATE_EN
    check("w4_overflow", r, 32'd15);
`else
    check("w4_overflow", r, 32'd4);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
